// File: rtl/gemm_inst_sequencer.sv
// Instruction sequencer for the systolic array: decodes LD/ST/GEMM/DRAINSYS, moves tiles
// between external memory and the SRAM banks, and steps the array control state.
module gemm_inst_sequencer #(
    parameter int NUM_ROW              = 4,
    parameter int NUM_COL              = 4,
    parameter int DATA_WIDTH           = 8,
    parameter int OUT_DATA_WIDTH       = 32,
    parameter int LOG2_SRAM_BANK_DEPTH = 5,
    parameter int CTRL_WIDTH           = 4,
    parameter int OPCODE_WIDTH         = 4,
    parameter int BUF_ID_WIDTH         = 2,
    parameter int MEM_LOC_WIDTH        = 10,
    parameter int WARMUP_CYCLES        = NUM_ROW,
    parameter int MEM_RD_WIDTH         = NUM_ROW * DATA_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                i_inst_valid,
    output logic                                o_inst_ready,
    input  logic [15:0]                         i_inst,
    output logic                                o_mem_rd_en,
    output logic [MEM_LOC_WIDTH-1:0]            o_mem_rd_addr,
    input  logic [MEM_RD_WIDTH-1:0]             i_mem_rd_data,
    output logic                                o_mem_wr_en,
    output logic [MEM_LOC_WIDTH-1:0]            o_mem_wr_addr,
    output logic [NUM_COL*OUT_DATA_WIDTH-1:0]   o_mem_wr_data,
    output logic                                o_top_wr_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_top_wr_addr,
    output logic [NUM_COL*DATA_WIDTH-1:0]       o_top_wr_data,
    output logic                                o_left_wr_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_left_wr_addr,
    output logic [NUM_ROW*DATA_WIDTH-1:0]       o_left_wr_data,
    output logic                                o_down_rd_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_down_rd_addr,
    input  logic [NUM_COL*OUT_DATA_WIDTH-1:0]   i_down_rd_data,
    output logic [CTRL_WIDTH-1:0]               o_ctrl_state,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_top_rd_start,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_top_rd_end,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_left_rd_start,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0]     o_left_rd_end,
    output logic                                o_done,
    output logic                                o_err,
    output logic [15:0]                         o_inst_count
);
    localparam int CNT_W = 16;
    localparam logic [OPCODE_WIDTH-1:0] OP_LD       = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_ST       = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_GEMM     = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_DRAINSYS = OPCODE_WIDTH'(5);

    typedef enum logic [2:0] {S_IDLE, S_LD, S_ST, S_WARM, S_STEADY, S_DRAIN, S_ERR} state_t;

    state_t                            state_reg, state_next;
    logic [CNT_W-1:0]                  cnt_reg, cnt_next;
    logic [MEM_LOC_WIDTH-1:0]          mem_loc_reg, mem_loc_next;
    logic                              ld_left_reg, ld_left_next;
    logic [LOG2_SRAM_BANK_DEPTH-1:0]   k_reg, k_next;
    logic [LOG2_SRAM_BANK_DEPTH-1:0]   win_end_reg, win_end_next;
    logic [15:0]                       count_reg;
    logic                              ready_reg;

    logic [OPCODE_WIDTH-1:0]           dec_op;
    logic [BUF_ID_WIDTH-1:0]           dec_buf;
    logic [MEM_LOC_WIDTH-1:0]          dec_loc;
    logic [LOG2_SRAM_BANK_DEPTH-1:0]   dec_k;
    logic [CNT_W-1:0]                  ld_len;
    logic                              wr_phase;

    assign dec_op  = i_inst[15 -: OPCODE_WIDTH];
    assign dec_buf = i_inst[MEM_LOC_WIDTH +: BUF_ID_WIDTH];
    assign dec_loc = i_inst[MEM_LOC_WIDTH-1:0];
    assign dec_k   = dec_loc[LOG2_SRAM_BANK_DEPTH-1:0];
    assign ld_len  = ld_left_reg ? CNT_W'(NUM_ROW) : CNT_W'(NUM_COL);
    // Bank/memory writes trail the reads by one cycle, so they run while cnt is 1..N.
    assign wr_phase = (cnt_reg != '0);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + CNT_W'(1);
        mem_loc_next = mem_loc_reg;
        ld_left_next = ld_left_reg;
        k_next       = k_reg;
        win_end_next = win_end_reg;
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (i_inst_valid && ready_reg) begin
                    mem_loc_next = dec_loc;
                    ld_left_next = (dec_buf == BUF_ID_WIDTH'(1));
                    k_next       = dec_k;
                    case (dec_op)
                        OP_LD:       state_next = (dec_buf <= BUF_ID_WIDTH'(1)) ? S_LD : S_ERR;
                        OP_ST:       state_next = S_ST;
                        OP_GEMM: begin
                            if (dec_k == '0) begin
                                state_next = S_ERR;
                            end else begin
                                state_next   = S_WARM;
                                win_end_next = dec_k;
                            end
                        end
                        OP_DRAINSYS: state_next = S_DRAIN;
                        default:     state_next = S_ERR;
                    endcase
                end
            end
            S_LD:     if (cnt_reg == ld_len) state_next = S_IDLE;
            S_ST:     if (cnt_reg == CNT_W'(NUM_ROW)) state_next = S_IDLE;
            S_WARM: begin
                if (cnt_reg == CNT_W'(WARMUP_CYCLES - 1)) begin
                    state_next = S_STEADY;
                    cnt_next   = '0;
                end
            end
            S_STEADY: begin
                if (cnt_reg == CNT_W'(k_reg) - CNT_W'(1)) begin
                    state_next = S_DRAIN;
                    cnt_next   = '0;
                end
            end
            S_DRAIN:  if (cnt_reg == CNT_W'(NUM_ROW + NUM_COL - 1)) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_mem_rd_en    = 1'b0;
        o_mem_rd_addr  = '0;
        o_mem_wr_en    = 1'b0;
        o_mem_wr_addr  = '0;
        o_mem_wr_data  = '0;
        o_top_wr_en    = 1'b0;
        o_top_wr_addr  = '0;
        o_top_wr_data  = '0;
        o_left_wr_en   = 1'b0;
        o_left_wr_addr = '0;
        o_left_wr_data = '0;
        o_down_rd_en   = 1'b0;
        o_down_rd_addr = '0;
        o_ctrl_state   = CTRL_WIDTH'(0);
        o_done         = 1'b0;
        o_err          = 1'b0;
        case (state_reg)
            S_LD: begin
                if (cnt_reg < ld_len) begin
                    o_mem_rd_en   = 1'b1;
                    o_mem_rd_addr = mem_loc_reg + MEM_LOC_WIDTH'(cnt_reg);
                end
                if (wr_phase && ld_left_reg) begin
                    o_left_wr_en   = 1'b1;
                    o_left_wr_addr = LOG2_SRAM_BANK_DEPTH'(cnt_reg - CNT_W'(1));
                    o_left_wr_data = i_mem_rd_data[NUM_ROW*DATA_WIDTH-1:0];
                end
                if (wr_phase && !ld_left_reg) begin
                    o_top_wr_en   = 1'b1;
                    o_top_wr_addr = LOG2_SRAM_BANK_DEPTH'(cnt_reg - CNT_W'(1));
                    o_top_wr_data = i_mem_rd_data[NUM_COL*DATA_WIDTH-1:0];
                end
                o_done = (cnt_reg == ld_len);
            end
            S_ST: begin
                if (cnt_reg < CNT_W'(NUM_ROW)) begin
                    o_down_rd_en   = 1'b1;
                    o_down_rd_addr = LOG2_SRAM_BANK_DEPTH'(cnt_reg);
                end
                if (wr_phase) begin
                    o_mem_wr_en   = 1'b1;
                    o_mem_wr_addr = mem_loc_reg + MEM_LOC_WIDTH'(cnt_reg - CNT_W'(1));
                    o_mem_wr_data = i_down_rd_data;
                end
                o_done = (cnt_reg == CNT_W'(NUM_ROW));
            end
            S_WARM:   o_ctrl_state = CTRL_WIDTH'(1);
            S_STEADY: o_ctrl_state = CTRL_WIDTH'(2);
            S_DRAIN: begin
                o_ctrl_state = CTRL_WIDTH'(3);
                o_done       = (cnt_reg == CNT_W'(NUM_ROW + NUM_COL - 1));
            end
            S_ERR:    o_err = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            mem_loc_reg <= '0;
            ld_left_reg <= 1'b0;
            k_reg       <= '0;
            win_end_reg <= '0;
            count_reg   <= '0;
            ready_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            mem_loc_reg <= mem_loc_next;
            ld_left_reg <= ld_left_next;
            k_reg       <= k_next;
            win_end_reg <= win_end_next;
            // Ready only while the FSM will sit in idle, so it is low during done/err cycles.
            ready_reg   <= (state_next == S_IDLE);
            if (o_done && count_reg != 16'hFFFF) count_reg <= count_reg + 16'd1;
        end
    end

    assign o_inst_ready    = ready_reg;
    assign o_inst_count    = count_reg;
    assign o_top_rd_start  = '0;
    assign o_left_rd_start = '0;
    assign o_top_rd_end    = win_end_reg;
    assign o_left_rd_end   = win_end_reg;
endmodule

// File: tb/tb_gemm_inst_sequencer.sv
// Directed bench for gemm_inst_sequencer: LD/GEMM/ST/DRAINSYS timing, errors, reset, back-to-back.
module tb_gemm_inst_sequencer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_inst_valid;
    logic         o_inst_ready;
    logic [15:0]  i_inst;
    logic         o_mem_rd_en;
    logic [9:0]   o_mem_rd_addr;
    logic [31:0]  i_mem_rd_data;
    logic         o_mem_wr_en;
    logic [9:0]   o_mem_wr_addr;
    logic [127:0] o_mem_wr_data;
    logic         o_top_wr_en;
    logic [4:0]   o_top_wr_addr;
    logic [31:0]  o_top_wr_data;
    logic         o_left_wr_en;
    logic [4:0]   o_left_wr_addr;
    logic [31:0]  o_left_wr_data;
    logic         o_down_rd_en;
    logic [4:0]   o_down_rd_addr;
    logic [127:0] i_down_rd_data;
    logic [3:0]   o_ctrl_state;
    logic [4:0]   o_top_rd_start, o_top_rd_end, o_left_rd_start, o_left_rd_end;
    logic         o_done, o_err;
    logic [15:0]  o_inst_count;

    int errors = 0;
    int checks = 0;

    gemm_inst_sequencer dut (
        .clk(clk), .rst_n(rst_n), .i_inst_valid(i_inst_valid), .o_inst_ready(o_inst_ready),
        .i_inst(i_inst), .o_mem_rd_en(o_mem_rd_en), .o_mem_rd_addr(o_mem_rd_addr),
        .i_mem_rd_data(i_mem_rd_data), .o_mem_wr_en(o_mem_wr_en), .o_mem_wr_addr(o_mem_wr_addr),
        .o_mem_wr_data(o_mem_wr_data), .o_top_wr_en(o_top_wr_en), .o_top_wr_addr(o_top_wr_addr),
        .o_top_wr_data(o_top_wr_data), .o_left_wr_en(o_left_wr_en), .o_left_wr_addr(o_left_wr_addr),
        .o_left_wr_data(o_left_wr_data), .o_down_rd_en(o_down_rd_en), .o_down_rd_addr(o_down_rd_addr),
        .i_down_rd_data(i_down_rd_data), .o_ctrl_state(o_ctrl_state),
        .o_top_rd_start(o_top_rd_start), .o_top_rd_end(o_top_rd_end),
        .o_left_rd_start(o_left_rd_start), .o_left_rd_end(o_left_rd_end),
        .o_done(o_done), .o_err(o_err), .o_inst_count(o_inst_count)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] drow(input int r);
        return {32'hD3000000 + 32'(r), 32'hD2000000 + 32'(r), 32'hD1000000 + 32'(r), 32'hD0000000 + 32'(r)};
    endfunction

    // External memory and down bank: one-cycle read latency.
    always @(posedge clk) begin
        i_mem_rd_data  <= o_mem_rd_en ? (32'h04030201 + 32'(o_mem_rd_addr)) : 32'h0;
        i_down_rd_data <= o_down_rd_en ? drow(int'(o_down_rd_addr)) : 128'h0;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_inst_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", o_inst_ready, 1'b1);
    endtask

    // Returns at the negedge of cycle 1 (first cycle after the accepting edge).
    task automatic send(input logic [15:0] inst);
        wait_ready();
        i_inst       = inst;
        i_inst_valid = 1'b1;
        @(negedge clk);
        i_inst_valid = 1'b0;
        i_inst       = 16'h0;
    endtask

    logic [9:0]  st_addr [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    logic [15:0] err_inst[3] = '{16'hF000, 16'h2800, 16'h4020};
    logic [15:0] b2b_inst[4] = '{16'h2420, 16'h2044, 16'h4004, 16'h3010};
    int          b2b_gap [3] = '{6, 6, 17};

    initial begin
        int cyc, prev;
        logic [3:0] exp_ctrl;
        rst_n = 1'b0; i_inst_valid = 1'b0; i_inst = 16'h0;
        i_mem_rd_data = '0; i_down_rd_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", o_inst_ready, 1'b0);
        chk("rst_ctrl", o_ctrl_state, 4'd0);
        chk("rst_count", o_inst_count, 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", o_inst_ready, 1'b1);

        // LD top, mem_loc 0x040
        send(16'h2040);
        for (int c = 1; c <= 5; c++) begin
            chk("ld_rd_en", o_mem_rd_en, c <= 4);
            chk("ld_rd_addr", o_mem_rd_addr, (c <= 4) ? 10'(16'h40 + c - 1) : 10'h0);
            chk("ld_top_wr_en", o_top_wr_en, c >= 2);
            if (c >= 2) begin
                chk("ld_top_wr_addr", o_top_wr_addr, 5'(c - 2));
                chk("ld_top_wr_data", o_top_wr_data, 32'h04030201 + 32'h40 + 32'(c - 2));
            end
            chk("ld_left_wr_en", o_left_wr_en, 1'b0);
            chk("ld_done", o_done, c == 5);
            chk("ld_ready", o_inst_ready, 1'b0);
            @(negedge clk);
        end
        chk("ld_count", o_inst_count, 16'd1);
        chk("ld_ready_back", o_inst_ready, 1'b1);
        $display("txn LD top 0x2040 count=%0d", o_inst_count);

        // GEMM K=4
        send(16'h4004);
        for (int c = 1; c <= 16; c++) begin
            exp_ctrl = (c <= 4) ? 4'd1 : (c <= 8) ? 4'd2 : 4'd3;
            chk("gemm_ctrl", o_ctrl_state, exp_ctrl);
            chk("gemm_done", o_done, c == 16);
            chk("gemm_ready", o_inst_ready, 1'b0);
            @(negedge clk);
        end
        chk("gemm_ctrl_idle", o_ctrl_state, 4'd0);
        chk("gemm_top_win", {o_top_rd_start, o_top_rd_end}, {5'd0, 5'd4});
        chk("gemm_left_win", {o_left_rd_start, o_left_rd_end}, {5'd0, 5'd4});
        chk("gemm_count", o_inst_count, 16'd2);
        $display("txn GEMM K=4 count=%0d", o_inst_count);

        // ST with address wrap
        send(16'h33FE);
        for (int c = 1; c <= 5; c++) begin
            chk("st_down_rd_en", o_down_rd_en, c <= 4);
            if (c <= 4) chk("st_down_rd_addr", o_down_rd_addr, 5'(c - 1));
            chk("st_wr_en", o_mem_wr_en, c >= 2);
            if (c >= 2) begin
                chk("st_wr_addr", o_mem_wr_addr, st_addr[c-2]);
                chk("st_wr_data", o_mem_wr_data, drow(c - 2));
            end
            chk("st_done", o_done, c == 5);
            @(negedge clk);
        end
        chk("st_count", o_inst_count, 16'd3);
        $display("txn ST 0x3FE count=%0d", o_inst_count);

        // Rejected instructions
        for (int i = 0; i < 3; i++) begin
            send(err_inst[i]);
            chk("err_pulse", o_err, 1'b1);
            chk("err_done", o_done, 1'b0);
            chk("err_strobes", {o_mem_rd_en, o_mem_wr_en, o_top_wr_en, o_left_wr_en, o_down_rd_en}, 5'b0);
            chk("err_ctrl", o_ctrl_state, 4'd0);
            chk("err_ready", o_inst_ready, 1'b0);
            @(negedge clk);
            chk("err_clear", o_err, 1'b0);
            chk("err_ready_back", o_inst_ready, 1'b1);
            chk("err_count", o_inst_count, 16'd3);
            $display("txn ERR inst=%h count=%0d", err_inst[i], o_inst_count);
        end
        chk("err_win_kept", o_top_rd_end, 5'd4);

        // DRAINSYS
        send(16'h5000);
        for (int c = 1; c <= 8; c++) begin
            chk("drain_ctrl", o_ctrl_state, 4'd3);
            chk("drain_done", o_done, c == 8);
            @(negedge clk);
        end
        chk("drain_ctrl_idle", o_ctrl_state, 4'd0);
        chk("drain_count", o_inst_count, 16'd4);
        $display("txn DRAINSYS count=%0d", o_inst_count);

        // Reset during STEADY
        send(16'h4004);
        repeat (5) @(negedge clk);
        chk("mid_steady", o_ctrl_state, 4'd2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_ctrl", o_ctrl_state, 4'd0);
        chk("mid_rst_done", o_done, 1'b0);
        chk("mid_rst_ready", o_inst_ready, 1'b0);
        chk("mid_rst_count", o_inst_count, 16'd0);
        chk("mid_rst_win", o_top_rd_end, 5'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready_back", o_inst_ready, 1'b1);
        send(16'h2100);
        for (int c = 1; c <= 5; c++) begin
            chk("post_rst_top_wr_en", o_top_wr_en, c >= 2);
            chk("post_rst_done", o_done, c == 5);
            if (c == 5) chk("post_rst_data", o_top_wr_data, 32'h04030201 + 32'h103);
            @(negedge clk);
        end
        chk("post_rst_count", o_inst_count, 16'd1);
        $display("txn reset-mid-GEMM then LD count=%0d", o_inst_count);

        // Back-to-back with valid held high
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        i_inst_valid = 1'b1;
        cyc = 0; prev = 0;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            i_inst = b2b_inst[i];
            while (!o_inst_ready && n < 100) begin
                @(negedge clk);
                cyc++;
                n++;
            end
            chk("b2b_accept", o_inst_ready, 1'b1);
            if (i > 0) chk("b2b_gap", 32'(cyc - prev), 32'(b2b_gap[i-1]));
            prev = cyc;
            @(negedge clk);
            cyc++;
            $display("txn b2b inst=%h accepted at cycle %0d", b2b_inst[i], prev);
        end
        i_inst_valid = 1'b0;
        wait_ready();
        chk("b2b_count", o_inst_count, 16'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
